// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 bank arbiter.
// The optional conflict counter is enabled with the macro L2_ARB_PERF_CNT_EN.
package l2_arb_pkg;

    // Top-level sequencer states
    typedef enum logic [1:0] {
        CHECK = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } arb_state_e;

    // Width of the optional conflict performance counter
    localparam int CNT_WIDTH = 32;

    // Byte-enable width for a given data width
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rr_arb_tree_lite.sv
// Combinational round-robin picker: first active request at or above the
// pointer, wrapping from NB_REQ-1 back to 0.
module rr_arb_tree_lite #(
    parameter int NB_REQ = 2,
    parameter int PTR_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]  rr_ptr_i,
    output logic [NB_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]  winner_o,
    output logic              valid_o
);

    // Scan requesters in priority order starting at the pointer
    always_comb begin
        int  idx;
        logic found;
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx = (int'(rr_ptr_i) + i) % NB_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                winner_o   = PTR_W'(idx);
                gnt_o[idx] = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter sharing one single-port L2 SRAM bank between NB_REQ
// requesters, with an optional zero-fill of the bank after reset.
// Define L2_ARB_PERF_CNT_EN to add the conflict counter ports.
module l2_bank_arbiter
    import l2_arb_pkg::*;
#(
    parameter int  NB_REQ     = 2,
    parameter int  ADDR_WIDTH = 13,
    parameter int  DATA_WIDTH = 32,
    parameter int  BANK_WORDS = 8192,
    localparam int BE_W       = be_width(DATA_WIDTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         init_ni,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ-1:0]            wen_i,
    input  logic [NB_REQ*BE_W-1:0]       be_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         busy_o,
    output logic                         mem_csn_o,
    output logic                         mem_wen_o,
    output logic [BE_W-1:0]              mem_be_o,
    output logic [ADDR_WIDTH-1:0]        mem_add_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
`ifdef L2_ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]         conflict_cnt_o,
    input  logic                         conflict_clr_i
`endif
);

    localparam int PTR_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int INIT_W = ADDR_WIDTH + 1;  // extra bit lets BANK_WORDS == 2**ADDR_WIDTH terminate

    arb_state_e              state_reg;
    logic [INIT_W-1:0]       init_cnt_reg;
    logic [PTR_W-1:0]        rr_ptr_reg;
    logic [NB_REQ-1:0]       r_valid_reg;
    logic                    hold_wen_reg;
    logic [BE_W-1:0]         hold_be_reg;
    logic [ADDR_WIDTH-1:0]   hold_add_reg;
    logic [DATA_WIDTH-1:0]   hold_wdata_reg;

    logic [NB_REQ-1:0]       arb_gnt;
    logic [PTR_W-1:0]        winner;
    logic                    arb_valid;
    logic                    run_grant;

    logic [BE_W-1:0]         be_arr    [NB_REQ];
    logic [ADDR_WIDTH-1:0]   add_arr   [NB_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NB_REQ];

    // Split the flat request buses into per-requester fields
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_unpack
        assign be_arr[gi]    = be_i[gi*BE_W +: BE_W];
        assign add_arr[gi]   = add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arb_tree_lite #(
        .NB_REQ (NB_REQ),
        .PTR_W  (PTR_W)
    ) u_rr_arb (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_reg),
        .gnt_o    (arb_gnt),
        .winner_o (winner),
        .valid_o  (arb_valid)
    );

    // Requests outside RUN are left pending, never granted
    assign run_grant = (state_reg == RUN) && arb_valid;
    assign gnt_o     = run_grant ? arb_gnt : '0;
    assign busy_o    = (state_reg == INIT);
    assign r_valid_o = r_valid_reg;
    assign r_rdata_o = mem_rdata_i;

    // Bank port mux: init writes, the granted requester, or idle with fields held
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = hold_wen_reg;
        mem_be_o    = hold_be_reg;
        mem_add_o   = hold_add_reg;
        mem_wdata_o = hold_wdata_reg;
        if (state_reg == INIT) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_be_o    = '1;
            mem_add_o   = init_cnt_reg[ADDR_WIDTH-1:0];
            mem_wdata_o = '0;
        end else if (run_grant) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = wen_i[winner];
            mem_be_o    = be_arr[winner];
            mem_add_o   = add_arr[winner];
            mem_wdata_o = wdata_arr[winner];
        end
    end

    // Sequencer, round-robin pointer, response valid and idle-hold registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= CHECK;
            init_cnt_reg   <= '0;
            rr_ptr_reg     <= '0;
            r_valid_reg    <= '0;
            hold_wen_reg   <= 1'b1;
            hold_be_reg    <= '0;
            hold_add_reg   <= '0;
            hold_wdata_reg <= '0;
        end else begin
            r_valid_reg <= gnt_o;
            if (!mem_csn_o) begin
                hold_wen_reg   <= mem_wen_o;
                hold_be_reg    <= mem_be_o;
                hold_add_reg   <= mem_add_o;
                hold_wdata_reg <= mem_wdata_o;
            end
            case (state_reg)
                CHECK: begin
                    init_cnt_reg <= '0;
                    state_reg    <= init_ni ? RUN : INIT;
                end
                INIT: begin
                    init_cnt_reg <= init_cnt_reg + INIT_W'(1);
                    if (init_cnt_reg == INIT_W'(BANK_WORDS - 1)) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (run_grant) begin
                        rr_ptr_reg <= (winner == PTR_W'(NB_REQ - 1)) ? '0 : winner + PTR_W'(1);
                    end
                end
                default: state_reg <= CHECK;
            endcase
        end
    end

`ifdef L2_ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] conflict_cnt_reg;
    logic                 conflict_now;

    assign conflict_now   = (state_reg == RUN) && ($countones(req_i) > 1);
    assign conflict_cnt_o = conflict_cnt_reg;

    // Saturating count of RUN cycles with two or more requests; clear has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_reg <= '0;
        end else if (conflict_clr_i) begin
            conflict_cnt_reg <= '0;
        end else if (conflict_now && (conflict_cnt_reg != '1)) begin
            conflict_cnt_reg <= conflict_cnt_reg + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Self-checking bench for l2_bank_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural model of the bank port.
module tb_l2_bank_arbiter;

    localparam int NB  = 3;
    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int BW  = 16;
    localparam int BEW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_ni = 1'b1;
    logic [NB-1:0]     req = '0;
    logic [NB-1:0]     wen = '1;
    logic [NB*BEW-1:0] be = '0;
    logic [NB*AW-1:0]  add = '0;
    logic [NB*DW-1:0]  wdata = '0;
    logic [NB-1:0]     gnt_o, r_valid_o;
    logic [DW-1:0]     r_rdata_o;
    logic              busy_o, mem_csn_o, mem_wen_o;
    logic [BEW-1:0]    mem_be_o;
    logic [AW-1:0]     mem_add_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     sram_rdata;
`ifdef L2_ARB_PERF_CNT_EN
    logic [31:0]       conflict_cnt;
    logic              conflict_clr = 1'b0;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    l2_bank_arbiter #(
        .NB_REQ     (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BANK_WORDS (BW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_ni     (init_ni),
        .req_i       (req),
        .wen_i       (wen),
        .be_i        (be),
        .add_i       (add),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .busy_o      (busy_o),
        .mem_csn_o   (mem_csn_o),
        .mem_wen_o   (mem_wen_o),
        .mem_be_o    (mem_be_o),
        .mem_add_o   (mem_add_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (sram_rdata)
`ifdef L2_ARB_PERF_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .conflict_clr_i (conflict_clr)
`endif
    );

    function automatic logic [DW-1:0] preload(input int a);
        if (a == 'h10) return 32'hAAAA5555;
        if (a == 'h20) return 32'h12345678;
        if (a == 7)    return 32'h11223344;
        return 32'hA5A50000 | DW'(a);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Bank SRAM: byte-masked write, registered read
    initial begin
        logic [DW-1:0] sram [DEPTH];
        for (int i = 0; i < DEPTH; i++) sram[i] = preload(i);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (!mem_csn_o) begin
                if (!mem_wen_o) begin
                    for (int b = 0; b < BEW; b++)
                        if (mem_be_o[b]) sram[mem_add_o][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                end else begin
                    sram_rdata <= sram[mem_add_o];
                end
            end
        end
    end

    // Reference model and per-cycle compare
    initial begin
        logic [DW-1:0]  shadow [DEPTH];
        int             m_cyc, m_rr, w;
        bit             m_init, m_pread;
        logic [NB-1:0]  m_pv, e_gnt;
        logic [DW-1:0]  m_pdata;
        logic           e_csn, e_busy, e_wen, h_wen;
        logic [BEW-1:0] e_be, h_be;
        logic [AW-1:0]  e_add, h_add;
        logic [DW-1:0]  e_wdata, h_wdata;
        for (int i = 0; i < DEPTH; i++) shadow[i] = preload(i);
        m_cyc = 0; m_rr = 0; m_init = 0; m_pread = 0; m_pv = '0; m_pdata = '0;
        h_wen = 1'b1; h_be = '0; h_add = '0; h_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_gnt", gnt_o, 0);
                check("rst_rvalid", r_valid_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_csn", mem_csn_o, 1);
                check("rst_wen", mem_wen_o, 1);
                check("rst_be", mem_be_o, 0);
                check("rst_add", mem_add_o, 0);
                check("rst_wdata", mem_wdata_o, 0);
                m_cyc = 0; m_rr = 0; m_pv = '0; m_pread = 0;
                h_wen = 1'b1; h_be = '0; h_add = '0; h_wdata = '0;
            end else begin
                if (m_cyc == 0) m_init = !init_ni;
                check("r_valid", r_valid_o, m_pv);
                if (m_pv != 0 && m_pread) check("r_rdata", r_rdata_o, m_pdata);
                e_gnt = '0; e_csn = 1'b1; e_busy = 1'b0;
                e_wen = h_wen; e_be = h_be; e_add = h_add; e_wdata = h_wdata;
                m_pread = 0;
                if (m_cyc == 0) begin
                    // sequencer decision cycle, nothing happens on the bank
                end else if (m_init && m_cyc <= BW) begin
                    e_busy = 1'b1; e_csn = 1'b0; e_wen = 1'b0; e_be = '1;
                    e_add = AW'(m_cyc - 1); e_wdata = '0;
                    shadow[m_cyc - 1] = '0;
                end else begin
                    w = -1;
                    for (int k = 0; k < NB; k++)
                        if (w < 0 && req[(m_rr + k) % NB]) w = (m_rr + k) % NB;
                    if (w >= 0) begin
                        e_gnt[w] = 1'b1; e_csn = 1'b0;
                        e_wen = wen[w]; e_be = be[w*BEW +: BEW];
                        e_add = add[w*AW +: AW]; e_wdata = wdata[w*DW +: DW];
                        m_rr = (w + 1) % NB;
                        if (e_wen) begin
                            m_pread = 1; m_pdata = shadow[e_add];
                        end else begin
                            for (int b = 0; b < BEW; b++)
                                if (e_be[b]) shadow[e_add][b*8 +: 8] = e_wdata[b*8 +: 8];
                        end
                    end
                end
                check("gnt", gnt_o, e_gnt);
                check("busy", busy_o, e_busy);
                check("mem_csn", mem_csn_o, e_csn);
                check("mem_wen", mem_wen_o, e_wen);
                check("mem_be", mem_be_o, e_be);
                check("mem_add", mem_add_o, e_add);
                check("mem_wdata", mem_wdata_o, e_wdata);
                if (!e_csn) begin
                    h_wen = e_wen; h_be = e_be; h_add = e_add; h_wdata = e_wdata;
                end
                m_pv = e_gnt;
                m_cyc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic [BEW-1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; wen[i] = w;
        be[i*BEW +: BEW] = b; add[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
    endtask

    // Reset, release just after a rising edge, return at the CHECK-cycle negedge
    task automatic do_reset(input logic init_skip);
        step();
        rst_n = 1'b0; init_ni = init_skip; req = '0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Count busy cycles of an init sequence and note its first address
    task automatic count_init(output int n, output int first_add);
        n = 0; first_add = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy_o) begin
                if (n == 0) first_add = int'(mem_add_o);
                n++;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nchk=%0d expected completion", nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, n, fa;
        logic [NB-1:0] g;

        // Skip init: directed arbitration checks on preloaded words
        do_reset(1'b1);
        step();
        drive(0, 1, 1, '0, AW'('h10), '0);
        drive(1, 1, 1, '0, AW'('h20), '0);
        @(negedge clk); check("dirA_gnt_n", gnt_o, 3'b001);
        step(); req[0] = 1'b0;
        @(negedge clk); check("dirA_gnt_n1", gnt_o, 3'b010);
        check("dirA_rv_n1", r_valid_o, 3'b001); check("dirA_rd0", r_rdata_o, 32'hAAAA5555);
        step(); req[1] = 1'b0;
        @(negedge clk); check("dirA_rv_n2", r_valid_o, 3'b010); check("dirA_rd1", r_rdata_o, 32'h12345678);

        // Continuous contention for 8 cycles
        step();
        req[0] = 1'b1; req[1] = 1'b1;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) check("alt_first", gnt_o, 3'b001);
            c0 += int'(gnt_o[0]); c1 += int'(gnt_o[1]);
            step();
        end
        req = '0;
        check("alt_cnt0", c0, 4); check("alt_cnt1", c1, 4);

        // Partial byte write then readback
        drive(0, 1, 0, 4'h3, AW'(7), 32'hDEADBEEF);
        @(negedge clk); check("wr_gnt", gnt_o, 3'b001);
        step(); drive(0, 1, 1, '0, AW'(7), '0);
        @(negedge clk);
        step(); req = '0;
        @(negedge clk); check("wr_rv", r_valid_o, 3'b001); check("wr_readback", r_rdata_o, 32'h1122BEEF);

        // Zero-fill after reset
        do_reset(1'b0);
        count_init(n, fa);
        check("init_len", n, BW); check("init_first", fa, 0);
        step(); drive(1, 1, 1, '0, AW'(5), '0);
        @(negedge clk);
        step(); req = '0;
        @(negedge clk); check("init_rd5_rv", r_valid_o, 3'b010); check("init_rd5", r_rdata_o, 0);

        // Reset in the middle of the fill restarts it from address 0
        do_reset(1'b0);
        repeat (7) @(negedge clk);
        check("mid_add6", mem_add_o, 6);
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        count_init(n, fa);
        check("reinit_len", n, BW); check("reinit_first", fa, 0);

        // Random traffic obeying the hold-until-granted rule
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); g = gnt_o;
            step();
            for (int i = 0; i < NB; i++) begin
                if (g[i] || !req[i]) begin
                    if ($urandom_range(0, 99) < 55)
                        drive(i, 1, 1'($urandom_range(0, 1)), BEW'($urandom), AW'($urandom_range(0, 47)), $urandom);
                    else
                        req[i] = 1'b0;
                end
            end
        end
        step(); req = '0;

`ifdef L2_ARB_PERF_CNT_EN
        conflict_clr = 1'b1;
        step(); conflict_clr = 1'b0;
        drive(0, 1, 1, '0, AW'(1), '0); drive(1, 1, 1, '0, AW'(2), '0);
        repeat (5) step();
        req = '0;
        @(negedge clk); check("perf_cnt5", conflict_cnt, 5);
        step(); conflict_clr = 1'b1; req[0] = 1'b1; req[1] = 1'b1;
        step(); conflict_clr = 1'b0; req = '0;
        @(negedge clk); check("perf_clr", conflict_cnt, 0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
